// File: rtl/maf_rr_scheduler_if.sv
// maf_rr_scheduler_if
// Bundles the sample-side and result-side handshakes of the shared
// moving-average engine.
//   in_valid/in_data/clr : per-channel sample request, packed sample, clear
//   in_ready             : one-hot (or zero) accept strobe back to the sources
//   out_valid/out_ready  : result register handshake
//   out_data/out_ch      : signed average and the channel that produced it
//   out_primed           : the window held N real samples for this result
// master = sources/consumer side, slave = the scheduler.
interface maf_rr_scheduler_if #(
  parameter int NCH        = 4,
  parameter int DATA_WIDTH = 10
);
  localparam int CHW = $clog2(NCH);

  logic [NCH-1:0]              in_valid;
  logic [NCH*DATA_WIDTH-1:0]   in_data;
  logic [NCH-1:0]              in_ready;
  logic [NCH-1:0]              clr;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [CHW-1:0]              out_ch;
  logic                        out_primed;

  modport master (
    output in_valid, in_data, clr, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_primed
  );

  modport slave (
    input  in_valid, in_data, clr, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_primed
  );
endinterface

// File: rtl/maf_rr_scheduler.sv
// maf_rr_scheduler
// One sliding-window (length N) moving-average datapath shared round-robin
// between NCH sample channels. Each channel keeps a private history, write
// pointer, running sum and fill count. At most one channel is accepted per
// cycle; its updated average is loaded into a valid/ready output register
// tagged with the channel number.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : maf_rr_scheduler_if.slave (sample requests, clears, result output)
module maf_rr_scheduler #(
  parameter int NCH        = 4,
  parameter int N          = 15,
  parameter int DATA_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  maf_rr_scheduler_if.slave    bus
);

  localparam int CHW = $clog2(NCH);
  localparam int WPW = $clog2(N);
  localparam int FW  = $clog2(N + 1);
  // N times the extreme sample fits exactly, so the running sum never wraps.
  localparam int SW  = DATA_WIDTH + $clog2(N);
  localparam logic signed [SW:0] N_DIV = N[SW:0];

  // Per-channel window state
  logic signed [DATA_WIDTH-1:0] hist_q [NCH][N];
  logic signed [DATA_WIDTH-1:0] hist_d [NCH][N];
  logic signed [SW-1:0]         sum_q  [NCH];
  logic signed [SW-1:0]         sum_d  [NCH];
  logic [WPW-1:0]               wp_q   [NCH];
  logic [WPW-1:0]               wp_d   [NCH];
  logic [FW-1:0]                fill_q [NCH];
  logic [FW-1:0]                fill_d [NCH];

  logic [CHW-1:0]               last_q, last_d;

  // Output register
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]               out_ch_q,    out_ch_d;
  logic                         out_primed_q, out_primed_d;

  // Arbitration / datapath
  logic [NCH-1:0]               eligible;
  logic [CHW-1:0]               grant;
  logic                         grant_found;
  logic                         accept;
  logic signed [DATA_WIDTH-1:0] din_arr [NCH];
  logic signed [DATA_WIDTH-1:0] din, old;
  logic signed [SW-1:0]         din_ext, old_ext, new_sum;
  logic signed [SW:0]           sum_wide, quot;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign din_arr[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign eligible = bus.in_valid & ~bus.clr;

  // Round-robin search starting one past the last granted channel.
  always_comb begin : arbiter
    logic [CHW-1:0] idx;
    idx         = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CHW'((int'(last_q) + k) % NCH);
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
    // Gated by rst so no source sees an accept while state is held in reset.
    accept = grant_found && (!out_valid_q || bus.out_ready) && !rst;
    bus.in_ready = '0;
    if (accept) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin : datapath
    din      = din_arr[grant];
    old      = hist_q[grant][wp_q[grant]];
    din_ext  = {{(SW-DATA_WIDTH){din[DATA_WIDTH-1]}}, din};
    old_ext  = {{(SW-DATA_WIDTH){old[DATA_WIDTH-1]}}, old};
    new_sum  = sum_q[grant] - old_ext + din_ext;
    sum_wide = {new_sum[SW-1], new_sum};
    // Signed division truncates toward zero.
    quot     = sum_wide / N_DIV;
  end

  always_comb begin : next_state
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned
    // and no latch is inferred.
    hist_d       = hist_q;
    sum_d        = sum_q;
    wp_d         = wp_q;
    fill_d       = fill_q;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_primed_d = out_primed_q;

    // A cleared channel is never granted in the same cycle, so this cannot
    // collide with the accept update below.
    for (int i = 0; i < NCH; i++) begin
      if (bus.clr[i]) begin
        for (int j = 0; j < N; j++) hist_d[i][j] = '0;
        sum_d[i]  = '0;
        wp_d[i]   = '0;
        fill_d[i] = '0;
      end
    end

    if (accept) begin
      hist_d[grant][wp_q[grant]] = din;
      sum_d[grant]  = new_sum;
      wp_d[grant]   = (wp_q[grant] == WPW'(N - 1)) ? '0 : wp_q[grant] + 1'b1;
      fill_d[grant] = (fill_q[grant] < FW'(N)) ? fill_q[grant] + 1'b1 : fill_q[grant];
      last_d        = grant;
      out_valid_d   = 1'b1;
      out_data_d    = quot[DATA_WIDTH-1:0];
      out_ch_d      = grant;
      out_primed_d  = (fill_q[grant] >= FW'(N - 1));
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the history is reset too; warm-up averages rely on unwritten
      // slots reading as zero.
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < N; j++) hist_q[i][j] <= '0;
        sum_q[i]  <= '0;
        wp_q[i]   <= '0;
        fill_q[i] <= '0;
      end
      last_q       <= CHW'(NCH - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_primed_q <= 1'b0;
    end else begin
      hist_q       <= hist_d;
      sum_q        <= sum_d;
      wp_q         <= wp_d;
      fill_q       <= fill_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_primed_q <= out_primed_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.out_primed = out_primed_q;

endmodule

// File: tb/tb_maf_rr_scheduler.sv
// tb_maf_rr_scheduler
// Directed bench for maf_rr_scheduler: reset, warm-up, round-robin order,
// backpressure, signed truncation and per-channel clear. Inputs are driven
// one time unit after the rising edge; outputs are checked there too.
module tb_maf_rr_scheduler;
  localparam int NCH = 4;
  localparam int N   = 15;
  localparam int DW  = 10;

  logic clk = 1'b0;
  logic rst;
  int   check_cnt = 0;
  int   err_cnt   = 0;

  always #5 clk = ~clk;

  maf_rr_scheduler_if #(.NCH(NCH), .DATA_WIDTH(DW)) bus ();

  maf_rr_scheduler #(.NCH(NCH), .N(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input logic [NCH-1:0] v, input logic [NCH-1:0] c,
                        input logic r);
    bus.in_valid  = v;
    bus.clr       = c;
    bus.out_ready = r;
  endtask

  task automatic set_data(input int ch, input int v);
    bus.in_data[ch*DW +: DW] = DW'(v);
  endtask

  task automatic check_out(input string tag, input logic v, input int d,
                           input int ch, input logic p);
    check({tag, ".valid"},  32'(bus.out_valid),  32'(v));
    check({tag, ".data"},   32'(bus.out_data),   d);
    check({tag, ".ch"},     32'(bus.out_ch),     ch);
    check({tag, ".primed"}, 32'(bus.out_primed), 32'(p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in('0, '0, 1'b1);
    bus.in_data = '0;
    cycle();
    cycle();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    // ---------------- Reset with random inputs ----------------
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid  = NCH'($urandom);
      bus.clr       = NCH'($urandom);
      bus.out_ready = 1'($urandom);
      bus.in_data   = (NCH*DW)'({$urandom, $urandom});
      settle();
      check("rst.in_ready", 32'(bus.in_ready), 0);
      check_out("rst", 1'b0, 0, 0, 1'b0);
      cycle();
    end
    set_in(4'b0101, '0, 1'b1);
    set_data(0, 100);
    rst = 1'b0;
    settle();
    check("rst.first_grant", 32'(bus.in_ready), 1);
    cycle();
    check_out("rst.first_out", 1'b1, 6, 0, 1'b0);
    // Reset mid-transfer clears the held result at once.
    set_in('0, '0, 1'b0);
    rst = 1'b1;
    settle();
    check_out("rst.async", 1'b0, 0, 0, 1'b0);
    cycle();

    // ---------------- Warm-up and steady state ----------------
    do_reset();
    set_in(4'b0001, '0, 1'b1);
    set_data(0, 100);
    settle();
    for (int k = 1; k <= 16; k++) begin
      check("warm.in_ready", 32'(bus.in_ready), 1);
      cycle();
      check_out($sformatf("warm[%0d]", k), 1'b1,
                (100 * ((k < N) ? k : N)) / N, 0, (k >= N));
    end

    // ---------------- Round-robin ----------------
    do_reset();
    set_in(4'b1111, '0, 1'b1);
    for (int i = 0; i < NCH; i++) set_data(i, 150 * (i + 1));
    settle();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rr.in_ready[%0d]", c), 32'(bus.in_ready), 1 << (c % 4));
      cycle();
      check($sformatf("rr.out_ch[%0d]", c), 32'(bus.out_ch), c % 4);
    end
    set_in(4'b1011, '0, 1'b1);
    settle();
    begin
      int exp_ch[4] = '{0, 1, 3, 0};
      for (int c = 0; c < 4; c++) begin
        check($sformatf("rr2.in_ready[%0d]", c), 32'(bus.in_ready), 1 << exp_ch[c]);
        cycle();
        check($sformatf("rr2.out_ch[%0d]", c), 32'(bus.out_ch), exp_ch[c]);
      end
    end

    // ---------------- Backpressure ----------------
    do_reset();
    set_in(4'b1000, '0, 1'b1);
    set_data(3, 150);
    set_data(0, 300);
    settle();
    check("bp.grant3", 32'(bus.in_ready), 8);
    cycle();
    check_out("bp.load", 1'b1, 10, 3, 1'b0);
    set_in(4'b1111, '0, 1'b0);
    settle();
    for (int c = 0; c < 5; c++) begin
      check("bp.in_ready", 32'(bus.in_ready), 0);
      check_out($sformatf("bp.hold[%0d]", c), 1'b1, 10, 3, 1'b0);
      cycle();
    end
    set_in(4'b0001, '0, 1'b1);
    settle();
    check("bp.release_grant", 32'(bus.in_ready), 1);
    cycle();
    check_out("bp.reload", 1'b1, 20, 0, 1'b0);
    set_in('0, '0, 1'b1);
    settle();
    cycle();
    check("bp.drained", 32'(bus.out_valid), 0);

    // ---------------- Signed truncation ----------------
    do_reset();
    set_in(4'b0100, '0, 1'b1);
    set_data(2, -1);
    settle();
    cycle();
    check_out("sgn.m1", 1'b1, 0, 2, 1'b0);
    set_data(2, -20);
    settle();
    cycle();
    check_out("sgn.m20", 1'b1, -1, 2, 1'b0);
    set_data(2, -512);
    settle();
    for (int j = 1; j <= 15; j++) begin
      cycle();
      if (j == 1)  check_out("sgn.m512_1",  1'b1, -35,  2, 1'b0);
      if (j == 13) check_out("sgn.m512_13", 1'b1, -445, 2, 1'b1);
      if (j == 15) check_out("sgn.m512_15", 1'b1, -512, 2, 1'b1);
    end

    // ---------------- Clear mid-stream ----------------
    do_reset();
    set_in(4'b1010, '0, 1'b1);
    set_data(1, 50);
    set_data(3, 200);
    settle();
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (c == 28) check_out("clr.ch1_primed", 1'b1, 50, 1, 1'b1);
      if (c == 29) check_out("clr.ch3_primed", 1'b1, 200, 3, 1'b1);
    end
    set_in(4'b1010, 4'b0010, 1'b1);
    settle();
    check("clr.in_ready1", 32'(bus.in_ready[1]), 0);
    check("clr.in_ready", 32'(bus.in_ready), 8);
    cycle();
    check_out("clr.ch3_during", 1'b1, 200, 3, 1'b1);
    set_in(4'b0010, '0, 1'b1);
    set_data(1, 30);
    settle();
    check("clr.regrant1", 32'(bus.in_ready), 2);
    cycle();
    check_out("clr.ch1_after", 1'b1, 2, 1, 1'b0);
    set_in(4'b1000, '0, 1'b1);
    settle();
    cycle();
    check_out("clr.ch3_after", 1'b1, 200, 3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/maf_rr_scheduler.md
# maf_rr_scheduler

Shared moving-average engine that time-multiplexes one sliding-window filter across `NCH` independent sample channels. It is placed between the per-channel sample sources and the downstream consumer of averaged data. Each cycle it grants at most one requesting channel using round-robin arbitration. For the granted channel it updates that channel's private window state and emits one channel-tagged average through a valid/ready output register.

## Interface
- `NCH`, default 4: number of channels; must be ≥ 2.
- `N`, default 15: window length in samples per channel; must be ≥ 2.
- `DATA_WIDTH`, default 10: signed sample and average width.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `in_valid`, input, `NCH`: bit i set means channel i presents a sample.
- `in_data`, input, `NCH*DATA_WIDTH`: signed sample of channel i in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_ready`, output, `NCH`: one-hot or zero; bit i set means channel i's sample is accepted this cycle.
- `clr`, input, `NCH`: bit i set means synchronous clear of channel i's window state.
- `out_valid`, output, 1: the output register holds a result.
- `out_ready`, input, 1: the consumer accepts the result.
- `out_data`, output, `DATA_WIDTH`: signed window average.
- `out_ch`, output, `$clog2(NCH)`: the channel that produced `out_data`.
- `out_primed`, output, 1: the channel's window held `N` real samples when this result was computed.

## Operation
- **Per-channel state:** history `hist[ch][0..N-1]`, write pointer `wp[ch]` (0..N-1), signed running sum `sum[ch]`, fill counter `fill[ch]` (0..N, saturating).
- **Sum width:** `SW = DATA_WIDTH + $clog2(N)`. This holds N × min/max sample exactly, so the sum never wraps.
- **Eligibility:** channel i is eligible when `in_valid[i]` is set and `clr[i]` is clear.
- **Arbitration:**
  - The search starts at `last+1` and wraps modulo `NCH`; the first eligible channel is `g`.
  - `in_ready[g] = 1` only when `!out_valid || out_ready`. All other `in_ready` bits are 0.
  - `in_ready` is combinational from `in_valid`, `clr`, `out_valid`, `out_ready` and registered state.
- **Accept:** an accept is `in_valid[g] && in_ready[g]`. On the accept edge:
  - `new_sum = sum[g] - hist[g][wp[g]] + din`, where `din` is channel g's sample.
  - `sum[g] <= new_sum`; `hist[g][wp[g]] <= din`.
  - `wp[g]` increments and wraps from N-1 to 0.
  - `fill[g] <= min(fill[g]+1, N)`.
  - `last <= g`.
  - Output register loads `out_data = new_sum / N` (signed division, truncation toward zero), `out_ch = g`, `out_primed = (fill[g]+1 >= N)`, and `out_valid = 1`.
- **Average uses the updated sum:** the emitted average already includes the sample just accepted; there is no one-sample lag.
- **Warm-up:** while `fill < N`, unwritten history slots are 0. The average therefore equals the partial sum divided by N, reported with `out_primed = 0`.
- **Output handshake:**
  - `out_valid && out_ready` with no new accept: `out_valid <= 0`.
  - Drain and new accept on the same edge: the register reloads and `out_valid` stays 1.
  - While `out_valid && !out_ready`: `out_data`, `out_ch` and `out_primed` hold stable and no channel is accepted.
- **Clear:**
  - `clr[i]` zeroes `hist[i][*]`, `sum[i]`, `wp[i]` and `fill[i]` on the next edge.
  - Channel i cannot be granted in a cycle where `clr[i]` is set, so clear and accept never collide.
  - A result from channel i already in the output register is still delivered unchanged.
  - Clearing channel i does not affect other channels or `last`.
- **Reset:**
  - All per-channel state is 0 and `last = NCH-1`, so channel 0 has first priority.
  - `out_valid`, `out_data`, `out_ch` and `out_primed` are 0.
  - Reset asserted mid-transfer discards the pending output and all window state immediately; no partial update survives.

## Timing
- Latency: a sample accepted at edge k has its average visible with `out_valid = 1` in the cycle after edge k.
- Throughput: one sample per cycle aggregate while `out_ready` stays high.
- Starvation bound: with continuous requests, every eligible channel is granted within `NCH` consecutive accept cycles.
- No combinational path from `out_ready` to `out_data`. `in_ready` depends combinationally on `out_ready`.

## Test plan
- **Reset:** hold `rst` with random inputs. Required: all outputs 0 and `in_ready = 0` throughout. After release, the first request from channels 0 and 2 together grants channel 0.
- **Warm-up and steady state:** channel 0 only, constant 100, 16 samples, `out_ready = 1`.
  - Samples 1..15 give `out_data` 6, 13, 20, …, 93, 100 (floor of 100k/15).
  - `out_primed = 1` first on sample 15; sample 16 gives 100 with `out_primed = 1`.
- **Round-robin:** all 4 channels valid continuously.
  - Required grant order 0, 1, 2, 3, 0, … with `out_ch` matching one cycle later.
  - Drop channel 2's valid: order becomes 0, 1, 3, 0.
- **Backpressure:** drop `out_ready` for 5 cycles while a result is held.
  - Required: `out_data`/`out_ch` stable, `in_ready = 0`.
  - On release: drain and reload on the same edge, no sample lost or duplicated.
- **Signed truncation:** channel 2, fresh state, sample -1 gives `out_data = 0`. A further sample -20 gives sum -21 and `out_data = -1`. Sample -512 ×15 gives -512.
- **Clear mid-stream:** channel 1 primed at 50.
  - Assert `clr[1]` while `in_valid[1] = 1`: required `in_ready[1] = 0` that cycle.
  - The next sample of 30 gives `out_data = 2` and `out_primed = 0`.
  - Channel 3 averages are unaffected.
